// File: rtl/rv_mem_pkg.sv
// Shared memory-subsystem definitions.
// Holds the instruction-memory loader state encoding and the constants that
// the fetch stage and the instruction memory must agree on (reset PC / base
// address and the instruction word size in bytes).
package rv_mem_pkg;

   typedef enum logic [1:0] {
      LD_IDLE = 2'd0,
      LD_LOAD = 2'd1,
      LD_DONE = 2'd2
   } load_state_e;

   // Byte address of the first instruction; IF resets its PC to this value.
   localparam int unsigned INS_START_DEFAULT = 64;
   localparam int unsigned INS_WORD_BYTES    = 4;

endpackage

// File: rtl/ins_mem_loader.sv
// Serial byte loader for the instruction memory.
// Sequences IDLE -> LOAD -> DONE, counts bytes written, and produces the
// byte write strobe and write index for the array held in ins_mem.
//   clk, reset      : clock, asynchronous active-high reset
//   load_start      : (re)start a load at offset 0; wins over load_valid
//   load_valid      : load byte present this cycle
//   load_last       : final byte of the image (qualified by load_valid)
//   state           : current loader state
//   wr_en / wr_idx  : write strobe and byte index for the array
//   load_count      : bytes written in the current or last load
module ins_mem_loader
   import rv_mem_pkg::*;
#(
   parameter int unsigned DEPTH_BYTES = 160,
   parameter int unsigned CNT_W       = $clog2(DEPTH_BYTES) + 1,
   parameter int unsigned IDX_W       = $clog2(DEPTH_BYTES)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load_start,
   input  logic              load_valid,
   input  logic              load_last,
   output load_state_e       state,
   output logic              wr_en,
   output logic [IDX_W-1:0]  wr_idx,
   output logic [CNT_W-1:0]  load_count
);

   load_state_e      state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      wr_en   = 1'b0;
      if (load_start) begin
         // Restart from offset 0; any byte presented alongside is dropped.
         state_d = LD_LOAD;
         count_d = '0;
      end else if (state_q == LD_LOAD && load_valid) begin
         wr_en   = 1'b1;
         count_d = count_q + 1'b1;
         // Writing the last in-range byte ends the load, so the index can
         // never run past the array.
         if (load_last || count_q == CNT_W'(DEPTH_BYTES - 1)) begin
            state_d = LD_DONE;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= LD_IDLE;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
      end
   end

   assign state      = state_q;
   assign wr_idx     = count_q[IDX_W-1:0];
   assign load_count = count_q;

endmodule

// File: rtl/ins_mem.sv
// Byte-addressed little-endian instruction memory with a serial loader.
// Fetch is combinational: ins_data/ins_err follow ins_addr in the same cycle.
//   clk, reset  : clock, asynchronous active-high reset (clears the array)
//   ins_addr    : fetch byte address from IF
//   ins_data    : fetched word, zero while loading or on error
//   ins_err     : fetch misaligned or out of range (never set while loading)
//   load_*      : loader interface, see ins_mem_loader
//   load_busy   : loader in LOAD; IF must be held in reset
//   load_done   : loader in DONE
//   load_count  : bytes written in the current or last load
module ins_mem
   import rv_mem_pkg::*;
#(
   parameter int unsigned INS_MEM_SIZE = 40,
   parameter int unsigned INS_START    = INS_START_DEFAULT
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic [31:0]                           ins_addr,
   output logic [31:0]                           ins_data,
   output logic                                  ins_err,
   input  logic                                  load_start,
   input  logic                                  load_valid,
   input  logic [7:0]                            load_byte,
   input  logic                                  load_last,
   output logic                                  load_busy,
   output logic                                  load_done,
   output logic [$clog2(INS_MEM_SIZE*4):0]       load_count
);

   localparam int unsigned DEPTH   = INS_MEM_SIZE * INS_WORD_BYTES;
   localparam int unsigned IDX_W   = $clog2(DEPTH);
   localparam int unsigned CNT_W   = IDX_W + 1;
   localparam logic [31:0] ADDR_LO = 32'(INS_START);
   localparam logic [31:0] ADDR_HI = 32'(INS_START + DEPTH - INS_WORD_BYTES);

   load_state_e      state;
   logic             wr_en;
   logic [IDX_W-1:0] wr_idx;
   logic [CNT_W-1:0] count;

   logic [7:0]       mem_q [DEPTH];

   ins_mem_loader #(
      .DEPTH_BYTES (DEPTH),
      .CNT_W       (CNT_W),
      .IDX_W       (IDX_W)
   ) u_loader (
      .clk        (clk),
      .reset      (reset),
      .load_start (load_start),
      .load_valid (load_valid),
      .load_last  (load_last),
      .state      (state),
      .wr_en      (wr_en),
      .wr_idx     (wr_idx),
      .load_count (count)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= 8'h00;
         end
      end else if (wr_en) begin
         mem_q[wr_idx] <= load_byte;
      end
   end

   // Offset is formed in 32 bits so addresses below the base wrap high and
   // are rejected by the range check rather than aliasing into the array.
   logic [31:0]      unused_offset;
   logic             in_range;
   logic             aligned;
   logic             fetch_ok;
   logic [IDX_W-1:0] rd_base;

   always_comb begin
      unused_offset = ins_addr - ADDR_LO;
      in_range      = (ins_addr >= ADDR_LO) && (ins_addr <= ADDR_HI);
      aligned       = (ins_addr[1:0] == 2'b00);
      fetch_ok      = in_range && aligned;
      // Index is pinned to 0 whenever it would not be used, keeping the
      // read ports inside the array.
      rd_base       = fetch_ok ? unused_offset[IDX_W-1:0] : '0;

      ins_data = 32'h0;
      ins_err  = 1'b0;
      if (state != LD_LOAD) begin
         if (fetch_ok) begin
            ins_data = {mem_q[rd_base + IDX_W'(3)], mem_q[rd_base + IDX_W'(2)],
                        mem_q[rd_base + IDX_W'(1)], mem_q[rd_base]};
         end else begin
            ins_err = 1'b1;
         end
      end
   end

   assign load_busy  = (state == LD_LOAD);
   assign load_done  = (state == LD_DONE);
   assign load_count = count;

endmodule

// File: tb/tb_ins_mem.sv
module tb_ins_mem;

   localparam int SIZE  = 40;
   localparam int BASE  = 64;
   localparam int BYTES = SIZE * 4;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] ins_addr = 32'h0;
   logic [31:0] ins_data;
   logic        ins_err;
   logic        load_start = 1'b0;
   logic        load_valid = 1'b0;
   logic [7:0]  load_byte = 8'h00;
   logic        load_last = 1'b0;
   logic        load_busy;
   logic        load_done;
   logic [8:0]  load_count;

   ins_mem #(.INS_MEM_SIZE(SIZE), .INS_START(BASE)) dut (
      .clk        (clk),
      .reset      (reset),
      .ins_addr   (ins_addr),
      .ins_data   (ins_data),
      .ins_err    (ins_err),
      .load_start (load_start),
      .load_valid (load_valid),
      .load_byte  (load_byte),
      .load_last  (load_last),
      .load_busy  (load_busy),
      .load_done  (load_done),
      .load_count (load_count)
   );

   always #5 clk = ~clk;

   // Reference model: byte image, "loading" flag, "finished" flag, count.
   byte unsigned m_mem [BYTES];
   bit           m_loading;
   bit           m_finished;
   int           m_count;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic void m_clear();
      for (int i = 0; i < BYTES; i++) m_mem[i] = 0;
      m_loading  = 0;
      m_finished = 0;
      m_count    = 0;
   endfunction

   function automatic bit m_ok(input logic [31:0] a);
      longint unsigned la = a;
      return (la >= BASE) && (la <= BASE + BYTES - 4) && (la % 4 == 0);
   endfunction

   function automatic logic [31:0] m_data(input logic [31:0] a);
      int o;
      if (m_loading || !m_ok(a)) return 32'h0;
      o = int'(a) - BASE;
      return {m_mem[o+3], m_mem[o+2], m_mem[o+1], m_mem[o]};
   endfunction

   function automatic logic m_err(input logic [31:0] a);
      if (m_loading) return 1'b0;
      return !m_ok(a);
   endfunction

   // One clock of loader stimulus with the model advanced at the same edge.
   task automatic cyc(input logic s, input logic v, input logic [7:0] b, input logic l);
      load_start = s; load_valid = v; load_byte = b; load_last = l;
      @(posedge clk);
      if (s) begin
         m_loading = 1; m_finished = 0; m_count = 0;
      end else if (m_loading && v) begin
         m_mem[m_count] = b;
         m_count++;
         if (l || m_count == BYTES) begin
            m_loading = 0; m_finished = 1;
         end
      end
      #1;
      load_start = 0; load_valid = 0; load_byte = 8'h00; load_last = 0;
   endtask

   task automatic fetch(input string tag, input logic [31:0] a);
      ins_addr = a;
      #1;
      chk({tag, ".data"}, ins_data, m_data(a));
      chk({tag, ".err"}, {31'h0, ins_err}, {31'h0, m_err(a)});
   endtask

   task automatic ctrl(input string tag);
      chk({tag, ".busy"}, {31'h0, load_busy}, {31'h0, m_loading});
      chk({tag, ".done"}, {31'h0, load_done}, {31'h0, m_finished});
      chk({tag, ".count"}, {23'h0, load_count}, 32'(m_count));
   endtask

   // Asynchronous reset pulse placed between clock edges.
   task automatic async_reset();
      #2 reset = 1'b1;
      m_clear();
      #1;
      ctrl("rst_now");
      #2 reset = 1'b0;
      #1;
   endtask

   logic [31:0] ra;

   initial begin
      m_clear();
      @(posedge clk); #1;
      async_reset();
      fetch("rst_f64", 32'd64);
      chk("rst_word_fixed", ins_data, 32'h0);
      ctrl("rst");

      // Full load, byte n = n
      cyc(1, 0, 8'h00, 0);
      ctrl("full_start");
      fetch("load_f64", 32'd64);
      fetch("load_f66", 32'd66);
      for (int n = 0; n < BYTES; n++) cyc(0, 1, 8'(n), 0);
      ctrl("full");
      chk("full_count_fixed", {23'h0, load_count}, 32'd160);
      ins_addr = 32'd64; #1;
      chk("full_w64_fixed", ins_data, 32'h03020100);
      ins_addr = 32'd220; #1;
      chk("full_w220_fixed", ins_data, 32'h9F9E9D9C);
      fetch("err_66", 32'd66);
      fetch("err_224", 32'd224);
      fetch("err_60", 32'd60);
      fetch("err_0", 32'd0);
      fetch("err_top", 32'hFFFF_FFFC);
      fetch("ok_216", 32'd216);

      // load_valid in DONE is ignored
      cyc(0, 1, 8'hEE, 0);
      cyc(0, 1, 8'hEE, 1);
      ctrl("done_ignore");
      fetch("done_ign_f64", 32'd64);

      // Early end after reset
      async_reset();
      cyc(0, 1, 8'h77, 0);   // ignored in IDLE
      cyc(1, 0, 8'h00, 0);
      cyc(0, 1, 8'h13, 0);
      cyc(0, 0, 8'h99, 1);   // load_last without valid does nothing
      cyc(0, 1, 8'h00, 0);
      cyc(0, 1, 8'h50, 0);
      cyc(0, 1, 8'h00, 1);
      ctrl("early");
      ins_addr = 32'd64; #1;
      chk("early_w64_fixed", ins_data, 32'h00500013);
      fetch("early_f64", 32'd64);
      fetch("early_f68", 32'd68);

      // Priority: restart wins over a same-cycle byte
      cyc(1, 0, 8'h00, 0);
      for (int n = 0; n < 5; n++) cyc(0, 1, 8'(8'h21 + n), 0);
      ctrl("prio_5");
      cyc(1, 1, 8'hAA, 0);
      ctrl("prio_restart");
      cyc(0, 1, 8'h11, 1);
      ctrl("prio_end");
      fetch("prio_f64", 32'd64);
      fetch("prio_f68", 32'd68);

      // Reset mid-load
      cyc(1, 0, 8'h00, 0);
      for (int n = 0; n < 10; n++) cyc(0, 1, 8'($urandom), 0);
      async_reset();
      ctrl("midrst");
      fetch("midrst_f64", 32'd64);
      fetch("midrst_f68", 32'd68);

      // Randomized loads with gaps, random early ends and restarts
      for (int t = 0; t < 6; t++) begin
         int len;
         len = (t == 0) ? BYTES + 5 : int'($urandom_range(1, BYTES));
         cyc(1, 0, 8'h00, 0);
         for (int n = 0; n < len && m_loading; n++) begin
            if ($urandom_range(0, 3) == 0) cyc(0, 0, 8'($urandom), 0);
            if ($urandom_range(0, 60) == 0) cyc(1, $urandom_range(0, 1) == 1, 8'($urandom), 0);
            cyc(0, 1, 8'($urandom), n == len - 1);
         end
         ctrl("rnd_ctrl");
         for (int k = 0; k < 12; k++) begin
            if ($urandom_range(0, 3) == 0) ra = $urandom;
            else ra = 32'($urandom_range(40, 240));
            fetch("rnd_fetch", ra);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #500000;
      n_errors++;
      $display("FAIL timeout: observed no finish expected finish");
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $fatal(1, "timeout");
   end

endmodule
